// File: rtl/rf_read_stage_if.sv
// Bus bundle for rf_read_stage: decode input, register-file read ports,
// execute output slot and writeback completions.
interface rf_read_stage_if;
    // Decode side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rj;
    logic [4:0]  in_rk;
    logic [4:0]  in_rd;
    logic        in_use_rj;
    logic        in_use_rk;
    logic        in_wen;
    // Register-file read ports (asynchronous)
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    // Execute side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_src1;
    logic [31:0] out_src2;
    logic [4:0]  out_rd;
    logic        out_wen;
    // Writeback completions
    logic        wb_valid;
    logic [4:0]  wb_waddr;

    // Environment side: decode, register file, execute and writeback
    modport master (
        output in_valid, in_pc, in_rj, in_rk, in_rd, in_use_rj, in_use_rk, in_wen,
        output rf_rdata1, rf_rdata2, out_ready, wb_valid, wb_waddr,
        input  in_ready, rf_raddr1, rf_raddr2,
        input  out_valid, out_pc, out_src1, out_src2, out_rd, out_wen
    );

    // Stage side
    modport slave (
        input  in_valid, in_pc, in_rj, in_rk, in_rd, in_use_rj, in_use_rk, in_wen,
        input  rf_rdata1, rf_rdata2, out_ready, wb_valid, wb_waddr,
        output in_ready, rf_raddr1, rf_raddr2,
        output out_valid, out_pc, out_src1, out_src2, out_rd, out_wen
    );
endinterface

// File: rtl/rf_read_stage.sv
// rf_read_stage: holds one decoded instruction, reads its operands from the
// register file and issues it to execute once no pending write blocks it.
// A per-register counter tracks writes issued but not yet written back.
module rf_read_stage #(
    parameter int unsigned PEND_W = 2
) (
    input  logic           i_clk,
    input  logic           i_reset,
    rf_read_stage_if.slave io_bus
);
    localparam logic [PEND_W-1:0] PendMax = '1;

    // Hold slot (fields from decode)
    logic        r_hold_valid;
    logic [31:0] r_hold_pc;
    logic [4:0]  r_hold_rj;
    logic [4:0]  r_hold_rk;
    logic [4:0]  r_hold_rd;
    logic        r_hold_use_rj;
    logic        r_hold_use_rk;
    logic        r_hold_wen;

    // Out slot (operands captured)
    logic        r_out_valid;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_src1;
    logic [31:0] r_out_src2;
    logic [4:0]  r_out_rd;
    logic        r_out_wen;

    // Pending-write scoreboard
    logic [PEND_W-1:0] r_pend [32];
    logic [PEND_W-1:0] w_pend_d [32];
    logic [31:0]       w_pend_inc;
    logic [31:0]       w_pend_dec;

    logic w_rj_busy;
    logic w_rk_busy;
    logic w_rd_full;
    logic w_hazard;
    logic w_fire;
    logic w_in_ready;
    logic w_accept;
    logic w_issue_wen;

    // A saturated destination counter also stalls, so the counter never wraps
    assign w_rj_busy   = r_hold_use_rj && (r_hold_rj != 5'd0) && (r_pend[r_hold_rj] != '0);
    assign w_rk_busy   = r_hold_use_rk && (r_hold_rk != 5'd0) && (r_pend[r_hold_rk] != '0);
    assign w_rd_full   = r_hold_wen && (r_hold_rd != 5'd0) && (r_pend[r_hold_rd] == PendMax);
    assign w_hazard    = r_hold_valid && (w_rj_busy || w_rk_busy || w_rd_full);
    assign w_fire      = r_hold_valid && !w_hazard && (!r_out_valid || io_bus.out_ready);
    assign w_in_ready  = !r_hold_valid || w_fire;
    assign w_accept    = io_bus.in_valid && w_in_ready;
    assign w_issue_wen = r_hold_wen && (r_hold_rd != 5'd0);

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.rf_raddr1 = r_hold_rj;
    assign io_bus.rf_raddr2 = r_hold_rk;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_pc    = r_out_pc;
    assign io_bus.out_src1  = r_out_src1;
    assign io_bus.out_src2  = r_out_src2;
    assign io_bus.out_rd    = r_out_rd;
    assign io_bus.out_wen   = r_out_wen;

    // Hold slot: load on accept, empty on issue when nothing new arrives
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_valid  <= 1'b0;
            r_hold_pc     <= '0;
            r_hold_rj     <= '0;
            r_hold_rk     <= '0;
            r_hold_rd     <= '0;
            r_hold_use_rj <= 1'b0;
            r_hold_use_rk <= 1'b0;
            r_hold_wen    <= 1'b0;
        end else if (w_accept) begin
            r_hold_valid  <= 1'b1;
            r_hold_pc     <= io_bus.in_pc;
            r_hold_rj     <= io_bus.in_rj;
            r_hold_rk     <= io_bus.in_rk;
            r_hold_rd     <= io_bus.in_rd;
            r_hold_use_rj <= io_bus.in_use_rj;
            r_hold_use_rk <= io_bus.in_use_rk;
            r_hold_wen    <= io_bus.in_wen;
        end else if (w_fire) begin
            r_hold_valid  <= 1'b0;
        end
    end

    // Out slot: capture operands on issue, drain when execute takes it
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_src1  <= '0;
            r_out_src2  <= '0;
            r_out_rd    <= '0;
            r_out_wen   <= 1'b0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_hold_pc;
            r_out_src1  <= r_hold_use_rj ? io_bus.rf_rdata1 : 32'd0;
            r_out_src2  <= r_hold_use_rk ? io_bus.rf_rdata2 : 32'd0;
            r_out_rd    <= r_hold_rd;
            r_out_wen   <= w_issue_wen;
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Scoreboard next state: +1 on issue of a writer, -1 on writeback, both cancel
    always_comb begin
        w_pend_inc = '0;
        w_pend_dec = '0;
        w_pend_inc[r_hold_rd]       = w_fire && w_issue_wen;
        w_pend_dec[io_bus.wb_waddr] = io_bus.wb_valid;
        w_pend_d[0] = '0;
        for (int r = 1; r < 32; r++) begin
            w_pend_d[r] = r_pend[r];
            if (w_pend_inc[r] && !w_pend_dec[r]) begin
                w_pend_d[r] = r_pend[r] + 1'b1;
            end else if (w_pend_dec[r] && !w_pend_inc[r] && (r_pend[r] != '0)) begin
                w_pend_d[r] = r_pend[r] - 1'b1;
            end
        end
    end

    // Scoreboard register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend <= '{default: '0};
        end else begin
            r_pend <= w_pend_d;
        end
    end
endmodule

// File: tb/tb_rf_read_stage.sv
// Bench for rf_read_stage: directed scenarios followed by a randomized run
// checked against an architectural (program-order) register model.
module tb_rf_read_stage;
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic [4:0]  rd;
        logic        urj;
        logic        urk;
        logic        wen;
        logic [31:0] res;
    } ins_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] res;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rf_preload;
    logic [31:0] wb_wdata;
    logic [31:0] rf [32];

    int n_tests = 0;
    int n_fail  = 0;

    rf_read_stage_if u_if ();

    rf_read_stage #(
        .PEND_W (2)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (u_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'd0;
        return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0000;
    endfunction

    // Register file model: asynchronous read, write at the clock edge
    assign u_if.rf_rdata1 = (u_if.rf_raddr1 == 5'd0) ? 32'd0 : rf[u_if.rf_raddr1];
    assign u_if.rf_rdata2 = (u_if.rf_raddr2 == 5'd0) ? 32'd0 : rf[u_if.rf_raddr2];

    always @(posedge clk) begin
        if (rf_preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (u_if.wb_valid && (u_if.wb_waddr != 5'd0)) begin
            rf[u_if.wb_waddr] <= wb_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] rj, input logic [4:0] rk,
                                input logic [4:0] rd, input logic urj, input logic urk,
                                input logic wen);
        ins_t i;
        i.pc = pc; i.rj = rj; i.rk = rk; i.rd = rd;
        i.urj = urj; i.urk = urk; i.wen = wen; i.res = 32'd0;
        return i;
    endfunction

    task automatic present(input ins_t i);
        u_if.in_valid  = 1'b1;
        u_if.in_pc     = i.pc;
        u_if.in_rj     = i.rj;
        u_if.in_rk     = i.rk;
        u_if.in_rd     = i.rd;
        u_if.in_use_rj = i.urj;
        u_if.in_use_rk = i.urk;
        u_if.in_wen    = i.wen;
    endtask

    task automatic idle_in();
        u_if.in_valid = 1'b0;
    endtask

    task automatic drive_wb(input logic [4:0] addr, input logic [31:0] data);
        u_if.wb_valid = 1'b1;
        u_if.wb_waddr = addr;
        wb_wdata      = data;
    endtask

    task automatic no_wb();
        u_if.wb_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input ins_t i, input logic [31:0] s1,
                             input logic [31:0] s2);
        check({tag, "_valid"}, 64'(u_if.out_valid), 64'(1'b1));
        check({tag, "_pc"}, 64'(u_if.out_pc), 64'(i.pc));
        check({tag, "_src"}, {u_if.out_src1, u_if.out_src2}, {s1, s2});
        check({tag, "_dst"}, 64'({u_if.out_rd, u_if.out_wen}),
              64'({i.rd, i.wen && (i.rd != 5'd0)}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t        ind [4];
        ins_t        cur;
        exp_t        e;
        exp_t        exp_q [$];
        wb_t         wb_q [$];
        wb_t         w;
        logic [31:0] areg [32];
        logic        have_cur;
        logic        draining;
        int          seq;
        int          n_consumed;

        rst = 1'b1; rf_preload = 1'b1; wb_wdata = '0;
        u_if.in_valid = 1'b0; u_if.in_pc = '0; u_if.in_rj = '0; u_if.in_rk = '0;
        u_if.in_rd = '0; u_if.in_use_rj = 1'b0; u_if.in_use_rk = 1'b0; u_if.in_wen = 1'b0;
        u_if.out_ready = 1'b1; u_if.wb_valid = 1'b0; u_if.wb_waddr = '0;
        tick(); tick();
        rst = 1'b0; rf_preload = 1'b0;
        #1;
        // Reset state
        check("rst_out_valid", 64'(u_if.out_valid), 64'(1'b0));
        check("rst_in_ready", 64'(u_if.in_ready), 64'(1'b1));
        check("rst_out_pc", 64'(u_if.out_pc), 64'd0);
        check("rst_out_src", {u_if.out_src1, u_if.out_src2}, 64'd0);
        check("rst_out_dst", 64'({u_if.out_rd, u_if.out_wen}), 64'd0);

        // Independent stream of four instructions
        ind[0] = mk(32'h100, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b1);
        ind[1] = mk(32'h104, 5'd3, 5'd4, 5'd11, 1'b1, 1'b1, 1'b1);
        ind[2] = mk(32'h108, 5'd5, 5'd6, 5'd12, 1'b1, 1'b1, 1'b0);
        ind[3] = mk(32'h10C, 5'd8, 5'd9, 5'd13, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 7; c++) begin
            if (c < 4) present(ind[c]); else idle_in();
            #1;
            if (c < 4) check("ind_in_ready", 64'(u_if.in_ready), 64'(1'b1));
            if (c >= 2 && c <= 5) begin
                check_out("ind", ind[c-2], init_val(int'(ind[c-2].rj)),
                          ind[c-2].urk ? init_val(int'(ind[c-2].rk)) : 32'd0);
            end else begin
                check("ind_idle", 64'(u_if.out_valid), 64'(1'b0));
            end
            tick();
        end

        // RAW hazard on r5
        present(mk(32'h200, 5'd1, 5'd6, 5'd5, 1'b1, 1'b0, 1'b1)); #1; tick();
        present(mk(32'h204, 5'd5, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0)); #1;
        check("raw_b_accept", 64'(u_if.in_ready), 64'(1'b1));
        tick();
        idle_in(); #1;
        check_out("raw_a", mk(32'h200, 5'd1, 5'd6, 5'd5, 1'b1, 1'b0, 1'b1), init_val(1), 32'd0);
        check("raw_stall_ready", 64'(u_if.in_ready), 64'(1'b0));
        tick();
        drive_wb(5'd5, 32'h1234); #1;
        check("raw_b_stalled", 64'(u_if.out_valid), 64'(1'b0));
        check("raw_b_stall_rdy", 64'(u_if.in_ready), 64'(1'b0));
        tick();
        no_wb(); #1;
        check("raw_b_wait", 64'(u_if.out_valid), 64'(1'b0));
        check("raw_b_release", 64'(u_if.in_ready), 64'(1'b1));
        tick(); #1;
        check_out("raw_b", mk(32'h204, 5'd5, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0), 32'h1234, 32'd0);
        tick();

        // r0 writer and r0 reader never stall
        present(mk(32'h300, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1)); #1; tick();
        present(mk(32'h304, 5'd0, 5'd0, 5'd15, 1'b1, 1'b1, 1'b0)); #1;
        check("r0_accept", 64'(u_if.in_ready), 64'(1'b1));
        tick();
        idle_in(); #1;
        check_out("r0_w", mk(32'h300, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1), init_val(2), 32'd0);
        check("r0_no_stall", 64'(u_if.in_ready), 64'(1'b1));
        tick(); #1;
        check_out("r0_r", mk(32'h304, 5'd0, 5'd0, 5'd15, 1'b1, 1'b1, 1'b0), 32'd0, 32'd0);
        tick();

        // Saturation: three writers to r7 issue, the fourth waits for a writeback
        for (int c = 0; c < 4; c++) begin
            present(mk(32'h400 + 32'(4 * c), 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1)); #1;
            check("sat_accept", 64'(u_if.in_ready), 64'(1'b1));
            tick();
        end
        idle_in(); #1;
        check("sat_full_ready", 64'(u_if.in_ready), 64'(1'b0));
        check("sat_w3_pc", 64'(u_if.out_pc), 64'(32'h408));
        tick(); #1;
        check("sat_w4_stall", 64'(u_if.out_valid), 64'(1'b0));
        check("sat_w4_stall_rdy", 64'(u_if.in_ready), 64'(1'b0));
        drive_wb(5'd7, 32'h77);
        tick();
        no_wb(); #1;
        check("sat_w4_release", 64'(u_if.in_ready), 64'(1'b1));
        tick(); #1;
        check_out("sat_w4", mk(32'h40C, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1), 32'd0, 32'd0);
        tick();

        // Issue of a writer to r9 coinciding with a writeback to r9
        present(mk(32'h500, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1)); #1; tick();
        present(mk(32'h504, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1)); #1; tick();
        present(mk(32'h508, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0));
        drive_wb(5'd9, 32'h99); #1;
        check("sim_x2_fire", 64'(u_if.in_ready), 64'(1'b1));
        tick();
        idle_in(); no_wb(); #1;
        check("sim_x2_pc", 64'(u_if.out_pc), 64'(32'h504));
        check("sim_r_stall", 64'(u_if.in_ready), 64'(1'b0));
        tick(); #1;
        check("sim_r_still", 64'(u_if.out_valid), 64'(1'b0));
        drive_wb(5'd9, 32'h9A);
        tick();
        no_wb(); #1;
        check("sim_r_release", 64'(u_if.in_ready), 64'(1'b1));
        tick(); #1;
        check_out("sim_r", mk(32'h508, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), 32'h9A, 32'd0);
        tick();

        // Stray writeback to r3 must not underflow its counter
        drive_wb(5'd3, 32'h33); #1; tick();
        no_wb();
        present(mk(32'h540, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0)); #1; tick();
        idle_in(); #1;
        check("stray_issue", 64'(u_if.in_ready), 64'(1'b1));
        tick(); #1;
        check_out("stray", mk(32'h540, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0), 32'h33, 32'd0);
        tick();

        // Backpressure: output held stable, hold fills, input blocked
        present(mk(32'h600, 5'd1, 5'd2, 5'd20, 1'b1, 1'b1, 1'b1)); #1; tick();
        u_if.out_ready = 1'b0;
        present(mk(32'h604, 5'd1, 5'd0, 5'd21, 1'b1, 1'b0, 1'b0)); #1;
        check("bp_p1_fire", 64'(u_if.in_ready), 64'(1'b1));
        tick();
        present(mk(32'h608, 5'd2, 5'd0, 5'd22, 1'b1, 1'b0, 1'b0));
        for (int c = 0; c < 3; c++) begin
            #1;
            check_out("bp_hold", mk(32'h600, 5'd1, 5'd2, 5'd20, 1'b1, 1'b1, 1'b1),
                      init_val(1), init_val(2));
            check("bp_in_ready", 64'(u_if.in_ready), 64'(1'b0));
            tick();
        end

        // Reset aborts everything and clears the scoreboard
        rst = 1'b1; idle_in(); u_if.out_ready = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("rst2_out_valid", 64'(u_if.out_valid), 64'(1'b0));
        check("rst2_in_ready", 64'(u_if.in_ready), 64'(1'b1));
        check("rst2_out_pc", 64'(u_if.out_pc), 64'd0);
        present(mk(32'h700, 5'd7, 5'd20, 5'd0, 1'b1, 1'b1, 1'b0)); #1; tick();
        idle_in(); #1;
        check("rst2_no_pend", 64'(u_if.in_ready), 64'(1'b1));
        tick(); #1;
        check_out("rst2_rd", mk(32'h700, 5'd7, 5'd20, 5'd0, 1'b1, 1'b1, 1'b0),
                  32'h77, init_val(20));
        tick();

        // Randomized run against a program-order register model
        rst = 1'b1; rf_preload = 1'b1;
        tick();
        rst = 1'b0; rf_preload = 1'b0;
        for (int i = 0; i < 32; i++) areg[i] = init_val(i);
        have_cur = 1'b0;
        seq = 0;
        n_consumed = 0;
        for (int c = 0; c < 1200; c++) begin
            draining = (c >= 400);
            if (!have_cur && !draining && ($urandom_range(0, 3) != 0)) begin
                cur = mk(32'h1000 + 32'(4 * seq), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 3) != 0));
                cur.res = $urandom;
                seq++;
                have_cur = 1'b1;
            end
            if (have_cur) present(cur); else idle_in();
            u_if.out_ready = draining ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            if ((wb_q.size() > 0) && (draining || ($urandom_range(0, 1) == 1))) begin
                drive_wb(wb_q[0].rd, wb_q[0].data);
            end else begin
                no_wb();
            end
            #1;
            if (u_if.out_valid && u_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", 64'(u_if.out_valid), 64'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    n_consumed++;
                    check("rand_pc", 64'(u_if.out_pc), 64'(e.pc));
                    check("rand_src", {u_if.out_src1, u_if.out_src2}, {e.src1, e.src2});
                    check("rand_dst", 64'({u_if.out_rd, u_if.out_wen}), 64'({e.rd, e.wen}));
                    if (e.wen) begin
                        w.rd = e.rd;
                        w.data = e.res;
                        wb_q.push_back(w);
                    end
                end
            end
            if (u_if.in_valid && u_if.in_ready) begin
                e.pc   = cur.pc;
                e.src1 = cur.urj ? areg[cur.rj] : 32'd0;
                e.src2 = cur.urk ? areg[cur.rk] : 32'd0;
                e.rd   = cur.rd;
                e.wen  = cur.wen && (cur.rd != 5'd0);
                e.res  = cur.res;
                if (e.wen) areg[cur.rd] = cur.res;
                exp_q.push_back(e);
                have_cur = 1'b0;
            end
            if (u_if.wb_valid) void'(wb_q.pop_front());
            tick();
            if (draining && (exp_q.size() == 0) && !have_cur) break;
        end
        idle_in(); no_wb();
        check("rand_drain_left", 64'(exp_q.size()), 64'd0);
        check("rand_cur_left", 64'(have_cur), 64'(1'b0));
        check("rand_count", 64'(n_consumed), 64'(seq));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_read_stage.md
# rf_read_stage

Operand-read pipeline stage directly upstream of the 32×32 register file's consumers and downstream of decode. It holds one decoded instruction, drives the register file's two asynchronous read ports, and blocks read-after-write hazards with a per-register pending-write scoreboard. Operands and destination info go to execute through a registered output slot with valid/ready handshake. Writeback completions from the register-file write port clear scoreboard entries.

## Interface
- PEND_W, 2: width of each per-register pending-write counter; max in-flight writes per register = 2^PEND_W − 1.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  32  instruction PC.
- in_rj, in_rk, in_rd  in  5 each  source 1, source 2, destination register numbers.
- in_use_rj, in_use_rk  in  1 each  instruction reads rj / rk.
- in_wen  in  1  instruction writes rd.
- rf_raddr1, rf_raddr2  out  5 each  register-file read addresses; held rj / rk.
- rf_rdata1, rf_rdata2  in  32 each  register-file read data, combinational; register 0 reads 0.
- out_valid  out  1  execute slot holds a valid instruction.
- out_ready  in  1  execute accepts the slot this cycle.
- out_pc, out_src1, out_src2  out  32 each  PC and operands.
- out_rd  out  5  destination.
- out_wen  out  1  destination write flag; forced 0 when rd = 0.
- wb_valid  in  1  register-file write happens at this edge.
- wb_waddr  in  5  register being written.

## Operation
- Two storage slots: hold (input-side, fields from decode) and out (output-side, operands captured).
- Accept: in_valid && in_ready at an edge loads hold; hold_valid ← 1.
- rf_raddr1 = hold_rj, rf_raddr2 = hold_rk, regardless of hold_valid.
- Scoreboard: 32 counters pend[r], PEND_W bits; pend[0] is always 0.
- hazard = hold_valid && ((hold_use_rj && hold_rj≠0 && pend[hold_rj]≠0) || (hold_use_rk && hold_rk≠0 && pend[hold_rk]≠0) || (hold_wen && hold_rd≠0 && pend[hold_rd] = max)).
- fire = hold_valid && !hazard && (!out_valid || out_ready).
- On fire: out ← {hold_pc, rf_rdata1 (0 if !use_rj), rf_rdata2 (0 if !use_rk), hold_rd, hold_wen && hold_rd≠0}; out_valid ← 1; if that wen, pend[hold_rd] += 1.
- No fire and out_ready: out_valid ← 0.
- in_ready = !hold_valid || fire (combinational). Hold clears on fire unless a new accept occurs in the same cycle.
- Writeback: wb_valid && wb_waddr≠0 → pend[wb_waddr] −= 1. Decrement at 0 is ignored (stays 0).
- Same edge, same register, increment and decrement: net unchanged.
- No bypass. A stalled reader issues the cycle after the decrement, when the register file already holds the new value.

## Timing
- Reset: hold_valid=0, out_valid=0, all pend=0, out_pc/src1/src2=0, out_rd=0, out_wen=0. in_ready=1 from the first cycle after reset. Reset aborts any held or output instruction; the scoreboard is lost, so the pipeline must be reset as a whole.
- Latency: accepted at edge E; if hazard-free and the out slot is free, fires at E+1; out_valid is high from E+1.
- Throughput: one instruction per cycle when there are no hazards and out_ready=1.
- Output fields are stable while out_valid && !out_ready.
- in_ready falls in the same cycle hazard rises or the out slot stalls.

## Test plan
- Independent stream: 4 instructions, in_valid=1, out_ready=1, no shared registers → out_valid high 4 consecutive cycles starting 1 cycle after the first accept; operands equal the preloaded register-file values.
- RAW: instruction A writes r5, instruction B reads r5 as rj → B stalls. wb_valid with waddr=5 and wdata=0x1234 at edge W → B fires at W+1 with out_src1=0x1234.
- r0: instruction writes r0, then a reader of r0 → no stall; out_wen=0; src=0; pend unchanged.
- Saturation (PEND_W=2): three writers to r7 issue, fourth writer stalls. One wb to r7 → fourth writer issues the next cycle.
- Simultaneous events: issue of a writer to r9 coincides with wb to r9 while pend[r9]=1 → pend[r9] remains 1. Stray wb to r3 with pend[r3]=0 → stays 0.
- Backpressure then reset: out_ready=0 for 3 cycles → out fields stable, in_ready=0 once hold is full. Assert reset → next cycle out_valid=0, in_ready=1, all pend 0.
